// File: rtl/mriscv_axil_pkg.sv
// Shared AXI4-Lite arbiter definitions.
// Holds the per-channel state encoding and the default master count
// and bus widths that are used by the arbiter block and its sub-module.
package mriscv_axil_pkg;

   localparam int unsigned NM_DEF = 2;
   localparam int unsigned AW_DEF = 32;
   localparam int unsigned DW_DEF = 32;

   // Both the read and the write channel sequence through these states.
   typedef enum logic [1:0] {
      CH_IDLE,
      CH_ADDR,
      CH_RESP
   } chan_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant register for one AXI4-Lite channel.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   req      - NM-wide request vector from the upstream masters
//   load     - capture a new grant (channel is idle and some request is set)
//   done     - transaction finished: drop the grant, remember the winner
//   gnt      - registered one-hot grant, zero while no transaction is held
module rr_arbiter
   import mriscv_axil_pkg::*;
#(
   parameter int unsigned NM = NM_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NM-1:0] req,
   input  logic          load,
   input  logic          done,
   output logic [NM-1:0] gnt
);

   localparam int unsigned LW = $clog2(NM);

   logic [LW-1:0] last_winner;
   logic [LW-1:0] gnt_idx;
   logic [NM-1:0] pick;
   logic          found;

   // Search starts just above last_winner, then wraps around to master 0.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NM; i++) begin
         if (!found && req[i] && (LW'(i) > last_winner)) begin
            pick[i] = 1'b1;
            found   = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NM; i++) begin
         if (!found && req[i]) begin
            pick[i] = 1'b1;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < NM; i++) begin
         if (gnt[i]) gnt_idx = LW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt         <= '0;
         last_winner <= LW'(NM - 1);
      end else if (done) begin
         gnt         <= '0;
         last_winner <= gnt_idx;
      end else if (load) begin
         gnt <= pick;
      end
   end

endmodule

// File: rtl/axil_rr_arbiter.sv
// NM-master to one-slave AXI4-Lite round-robin arbiter.
// Read and write channels are arbitrated independently, each holding at
// most one outstanding transaction (IDLE -> ADDR -> RESP).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   s_AR*/s_R*           - per-master read address / read data (upstream)
//   s_AW*/s_W*/s_B*      - per-master write address / data / response
//   AR*/R*/AW*/W*/B*     - single downstream AXI4-Lite master port
//   rd_gnt, wr_gnt       - one-hot current grants, zero when idle
module axil_rr_arbiter
   import mriscv_axil_pkg::*;
#(
   parameter int unsigned NM = NM_DEF,
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NM-1:0]          s_ARvalid,
   input  logic [NM*AW-1:0]       s_ARdata,
   input  logic [NM*3-1:0]        s_ARprot,
   output logic [NM-1:0]          s_ARready,
   output logic [NM-1:0]          s_Rvalid,
   input  logic [NM-1:0]          s_RReady,
   output logic [DW-1:0]          s_Rdata,
   input  logic [NM-1:0]          s_AWvalid,
   input  logic [NM*AW-1:0]       s_AWdata,
   input  logic [NM*3-1:0]        s_AWprot,
   output logic [NM-1:0]          s_AWready,
   input  logic [NM-1:0]          s_Wvalid,
   input  logic [NM*DW-1:0]       s_Wdata,
   input  logic [NM*(DW/8)-1:0]   s_Wstrb,
   output logic [NM-1:0]          s_Wready,
   output logic [NM-1:0]          s_Bvalid,
   input  logic [NM-1:0]          s_Bready,
   output logic                   ARvalid,
   output logic [AW-1:0]          ARdata,
   output logic [2:0]             ARprot,
   input  logic                   ARready,
   input  logic                   Rvalid,
   output logic                   RReady,
   input  logic [DW-1:0]          Rdata,
   output logic                   AWvalid,
   output logic [AW-1:0]          AWdata,
   output logic [2:0]             AWprot,
   input  logic                   AWready,
   output logic                   Wvalid,
   output logic [DW-1:0]          Wdata,
   output logic [DW/8-1:0]        Wstrb,
   input  logic                   Wready,
   input  logic                   Bvalid,
   output logic                   Bready,
   output logic [NM-1:0]          rd_gnt,
   output logic [NM-1:0]          wr_gnt
);

   chan_state_t   rd_state, rd_state_n;
   chan_state_t   wr_state, wr_state_n;
   logic          aw_done, aw_done_n;
   logic          w_done, w_done_n;
   logic [NM-1:0] rd_gnt_q, wr_gnt_q;
   logic          rd_load, rd_done;
   logic          wr_load, wr_done;

   rr_arbiter #(.NM(NM)) u_rd_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (s_ARvalid),
      .load (rd_load),
      .done (rd_done),
      .gnt  (rd_gnt_q)
   );

   rr_arbiter #(.NM(NM)) u_wr_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (s_AWvalid),
      .load (wr_load),
      .done (wr_done),
      .gnt  (wr_gnt_q)
   );

   // Grants and every output below are forced low while rst is high, so
   // nothing leaks out during the reset cycle even before state clears.
   assign rd_gnt = rst ? '0 : rd_gnt_q;
   assign wr_gnt = rst ? '0 : wr_gnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= CH_IDLE;
         wr_state <= CH_IDLE;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         rd_state <= rd_state_n;
         wr_state <= wr_state_n;
         aw_done  <= aw_done_n;
         w_done   <= w_done_n;
      end
   end

   // Read channel: next state and outputs.
   always_comb begin
      rd_state_n = rd_state;
      rd_load    = 1'b0;
      rd_done    = 1'b0;
      ARvalid    = 1'b0;
      ARdata     = '0;
      ARprot     = '0;
      RReady     = 1'b0;
      s_ARready  = '0;
      s_Rvalid   = '0;
      s_Rdata    = '0;
      if (!rst) begin
         for (int unsigned i = 0; i < NM; i++) begin
            if (rd_gnt_q[i]) begin
               ARdata = s_ARdata[i*AW +: AW];
               ARprot = s_ARprot[i*3 +: 3];
            end
         end
         case (rd_state)
            CH_IDLE: begin
               if (|s_ARvalid) begin
                  rd_load    = 1'b1;
                  rd_state_n = CH_ADDR;
               end
            end
            CH_ADDR: begin
               ARvalid   = 1'b1;
               s_ARready = rd_gnt_q & {NM{ARready}};
               if (ARready) rd_state_n = CH_RESP;
            end
            CH_RESP: begin
               s_Rvalid = rd_gnt_q & {NM{Rvalid}};
               RReady   = |(s_RReady & rd_gnt_q);
               s_Rdata  = Rdata;
               if (Rvalid && RReady) begin
                  rd_done    = 1'b1;
                  rd_state_n = CH_IDLE;
               end
            end
            default: rd_state_n = CH_IDLE;
         endcase
      end
   end

   // Write channel: AW and W may complete in either order or together;
   // the done flags stop re-presenting a beat that was already accepted.
   always_comb begin
      wr_state_n = wr_state;
      aw_done_n  = aw_done;
      w_done_n   = w_done;
      wr_load    = 1'b0;
      wr_done    = 1'b0;
      AWvalid    = 1'b0;
      AWdata     = '0;
      AWprot     = '0;
      Wvalid     = 1'b0;
      Wdata      = '0;
      Wstrb      = '0;
      Bready     = 1'b0;
      s_AWready  = '0;
      s_Wready   = '0;
      s_Bvalid   = '0;
      if (!rst) begin
         for (int unsigned i = 0; i < NM; i++) begin
            if (wr_gnt_q[i]) begin
               AWdata = s_AWdata[i*AW +: AW];
               AWprot = s_AWprot[i*3 +: 3];
               Wdata  = s_Wdata[i*DW +: DW];
               Wstrb  = s_Wstrb[i*(DW/8) +: (DW/8)];
            end
         end
         case (wr_state)
            CH_IDLE: begin
               if (|s_AWvalid) begin
                  wr_load    = 1'b1;
                  wr_state_n = CH_ADDR;
               end
            end
            CH_ADDR: begin
               AWvalid   = ~aw_done;
               Wvalid    = |(s_Wvalid & wr_gnt_q) & ~w_done;
               s_AWready = wr_gnt_q & {NM{AWready & ~aw_done}};
               s_Wready  = wr_gnt_q & {NM{Wready & ~w_done}};
               aw_done_n = aw_done | (AWvalid & AWready);
               w_done_n  = w_done | (Wvalid & Wready);
               if (aw_done_n && w_done_n) wr_state_n = CH_RESP;
            end
            CH_RESP: begin
               s_Bvalid = wr_gnt_q & {NM{Bvalid}};
               Bready   = |(s_Bready & wr_gnt_q);
               if (Bvalid && Bready) begin
                  wr_done    = 1'b1;
                  aw_done_n  = 1'b0;
                  w_done_n   = 1'b0;
                  wr_state_n = CH_IDLE;
               end
            end
            default: wr_state_n = CH_IDLE;
         endcase
      end
   end

endmodule
